// File: rtl/combo_lock_core.sv
// combo_lock_core
//   Keypad combination-lock engine: digit entry, code compare, consecutive
//   failure counting with a timed lockout, and in-field code reprogramming.
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   rst           asynchronous active-low reset
//   digit_in      digit value, sampled when digit_valid=1
//   digit_valid   single-cycle strobe: accept digit_in
//   clear         pulse: discard the partial entry
//   lock_req      pulse: lock, or abort programming
//   prog_req      pulse: enter code-programming mode (from UNLOCKED only)
//   state         00 LOCKED, 01 UNLOCKED, 10 PROGRAM, 11 LOCKOUT
//   entry         partial entry, newest digit in the LSBs
//   entry_cnt     digits currently held
//   fail_cnt      consecutive failed attempts
//   bad_code      one-cycle pulse on a mismatching complete entry
//   lockout_left  remaining lockout cycles (0 outside LOCKOUT)
//
// Input priority in any cycle: lock_req > prog_req > clear > digit_valid.
// A higher-priority input swallows the cycle even when the current state
// ignores it.
module combo_lock_core #(
  parameter int DIGITS         = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 100000000,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DIGIT_W-1:0]                digit_in,
  input  logic                              digit_valid,
  input  logic                              clear,
  input  logic                              lock_req,
  input  logic                              prog_req,
  output logic [1:0]                        state,
  output logic [DIGITS*DIGIT_W-1:0]         entry,
  output logic [$clog2(DIGITS+1)-1:0]       entry_cnt,
  output logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt,
  output logic                              bad_code,
  output logic [$clog2(LOCKOUT_CYCLES)-1:0] lockout_left
);

  localparam int EW     = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int LO_W   = $clog2(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'b00,
    S_UNLOCKED = 2'b01,
    S_PROGRAM  = 2'b10,
    S_LOCKOUT  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     entry_q, entry_d;
  logic [CNT_W-1:0]  entry_cnt_q, entry_cnt_d;
  logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
  logic              bad_code_q, bad_code_d;
  logic [LO_W-1:0]   lockout_left_q, lockout_left_d;
  logic [EW-1:0]     code_q, code_d;

  logic [EW-1:0]     next_entry;
  logic              completing;

  // Shift written as a full-width shift so DIGITS=1 needs no special slice.
  assign next_entry = EW'(entry_q << DIGIT_W) | EW'(digit_in);
  assign completing = (entry_cnt_q == CNT_W'(DIGITS - 1));

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    entry_d        = entry_q;
    entry_cnt_d    = entry_cnt_q;
    fail_cnt_d     = fail_cnt_q;
    bad_code_d     = 1'b0;
    lockout_left_d = lockout_left_q;
    code_d         = code_q;

    unique case (state_q)
      S_LOCKED: begin
        if (lock_req || (!prog_req && clear)) begin
          entry_d     = '0;
          entry_cnt_d = '0;
        end else if (!prog_req && digit_valid) begin
          if (completing) begin
            entry_d     = '0;
            entry_cnt_d = '0;
            if (next_entry == code_q) begin
              state_d    = S_UNLOCKED;
              fail_cnt_d = '0;
            end else begin
              bad_code_d = 1'b1;
              if (fail_cnt_q >= FAIL_W'(MAX_FAILS - 1)) begin
                // Final allowed failure: counter parks at MAX_FAILS for the
                // whole lockout.
                state_d        = S_LOCKOUT;
                fail_cnt_d     = FAIL_W'(MAX_FAILS);
                lockout_left_d = LO_W'(LOCKOUT_CYCLES - 1);
              end else begin
                fail_cnt_d = fail_cnt_q + FAIL_W'(1);
              end
            end
          end else begin
            entry_d     = next_entry;
            entry_cnt_d = entry_cnt_q + CNT_W'(1);
          end
        end
      end

      S_UNLOCKED: begin
        if (lock_req) begin
          state_d = S_LOCKED;
        end else if (prog_req) begin
          state_d     = S_PROGRAM;
          entry_d     = '0;
          entry_cnt_d = '0;
        end
      end

      S_PROGRAM: begin
        if (lock_req) begin
          state_d     = S_LOCKED;
          entry_d     = '0;
          entry_cnt_d = '0;
        end else if (prog_req) begin
          // already programming: nothing to do
        end else if (clear) begin
          entry_d     = '0;
          entry_cnt_d = '0;
        end else if (digit_valid) begin
          if (completing) begin
            code_d      = next_entry;
            state_d     = S_UNLOCKED;
            entry_d     = '0;
            entry_cnt_d = '0;
          end else begin
            entry_d     = next_entry;
            entry_cnt_d = entry_cnt_q + CNT_W'(1);
          end
        end
      end

      S_LOCKOUT: begin
        // Lockout spans LOCKOUT_CYCLES cycles: values LOCKOUT_CYCLES-1 .. 0.
        if (lockout_left_q == '0) begin
          state_d    = S_LOCKED;
          fail_cnt_d = '0;
        end else begin
          lockout_left_d = lockout_left_q - LO_W'(1);
        end
      end

      default: state_d = S_LOCKED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_LOCKED;
      entry_q        <= '0;
      entry_cnt_q    <= '0;
      fail_cnt_q     <= '0;
      bad_code_q     <= 1'b0;
      lockout_left_q <= '0;
      // NOTE: the code register is reset on purpose: a reset must drop any
      // field-programmed code and fall back to the factory default.
      code_q         <= DEFAULT_CODE;
    end else begin
      state_q        <= state_d;
      entry_q        <= entry_d;
      entry_cnt_q    <= entry_cnt_d;
      fail_cnt_q     <= fail_cnt_d;
      bad_code_q     <= bad_code_d;
      lockout_left_q <= lockout_left_d;
      code_q         <= code_d;
    end
  end

  assign state        = state_q;
  assign entry        = entry_q;
  assign entry_cnt    = entry_cnt_q;
  assign fail_cnt     = fail_cnt_q;
  assign bad_code     = bad_code_q;
  assign lockout_left = lockout_left_q;

endmodule

// File: tb/tb_combo_lock_core.sv
// tb_combo_lock_core
//   Directed bench for combo_lock_core (DIGITS=4, DIGIT_W=4, MAX_FAILS=3,
//   LOCKOUT_CYCLES=8, DEFAULT_CODE=16'h1234). Each stimulus cycle queues the
//   hand-computed register snapshot expected after the sampling edge; a
//   monitor pops and compares snapshots on the falling edge.
module tb_combo_lock_core;

  logic        clk;
  logic        rst;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        clear;
  logic        lock_req;
  logic        prog_req;
  logic [1:0]  state;
  logic [15:0] entry;
  logic [2:0]  entry_cnt;
  logic [1:0]  fail_cnt;
  logic        bad_code;
  logic [2:0]  lockout_left;

  combo_lock_core #(
    .DIGITS(4), .DIGIT_W(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(8),
    .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .lock_req(lock_req), .prog_req(prog_req),
    .state(state), .entry(entry), .entry_cnt(entry_cnt),
    .fail_cnt(fail_cnt), .bad_code(bad_code), .lockout_left(lockout_left)
  );

  typedef struct {
    int          tgt;
    string       name;
    logic [1:0]  st;
    logic [15:0] ent;
    logic [2:0]  ecnt;
    logic [1:0]  fcnt;
    logic        bad;
    logic [2:0]  lol;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Monitor: compare every expectation whose target cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].tgt <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.tgt != cyc || state !== e.st || entry !== e.ent ||
          entry_cnt !== e.ecnt || fail_cnt !== e.fcnt ||
          bad_code !== e.bad || lockout_left !== e.lol) begin
        bad++;
        $display("FAIL %s @%0d: got st=%0d entry=%h cnt=%0d fail=%0d bad=%0b left=%0d, want st=%0d entry=%h cnt=%0d fail=%0d bad=%0b left=%0d",
                 e.name, cyc, state, entry, entry_cnt, fail_cnt, bad_code,
                 lockout_left, e.st, e.ent, e.ecnt, e.fcnt, e.bad, e.lol);
      end
    end
  end

  // Drive one cycle of inputs and queue the snapshot expected after the edge.
  task automatic step(input string nm, input logic lk, input logic pr,
                      input logic cl, input logic dv, input logic [3:0] d,
                      input logic [1:0] st, input logic [15:0] ent,
                      input logic [2:0] ec, input logic [1:0] fc,
                      input logic bd, input logic [2:0] lol);
    exp_t e;
    lock_req = lk; prog_req = pr; clear = cl; digit_valid = dv; digit_in = d;
    e.tgt = cyc + 1; e.name = nm; e.st = st; e.ent = ent; e.ecnt = ec;
    e.fcnt = fc; e.bad = bd; e.lol = lol;
    sb.push_back(e);
    @(posedge clk);
    #1;
    lock_req = 0; prog_req = 0; clear = 0; digit_valid = 0; digit_in = '0;
  endtask

  task automatic dig(input string nm, input logic [3:0] d, input logic [1:0] st,
                     input logic [15:0] ent, input logic [2:0] ec,
                     input logic [1:0] fc, input logic bd, input logic [2:0] lol);
    step(nm, 0, 0, 0, 1, d, st, ent, ec, fc, bd, lol);
  endtask

  // Enter a 4-digit code from LOCKED (fail_cnt=fc) that is expected to unlock.
  task automatic unlock4(input string nm, input logic [15:0] code,
                         input logic [1:0] fc);
    dig({nm, "_d1"}, code[15:12], 2'd0, {12'h0, code[15:12]}, 3'd1, fc, 0, 0);
    dig({nm, "_d2"}, code[11:8],  2'd0, {8'h0, code[15:8]},   3'd2, fc, 0, 0);
    dig({nm, "_d3"}, code[7:4],   2'd0, {4'h0, code[15:4]},   3'd3, fc, 0, 0);
    dig({nm, "_d4"}, code[3:0],   2'd1, 16'h0,                3'd0, 2'd0, 0, 0);
  endtask

  // Enter a 4-digit code in PROGRAM mode; ends UNLOCKED.
  task automatic program4(input string nm, input logic [15:0] code);
    dig({nm, "_p1"}, code[15:12], 2'd2, {12'h0, code[15:12]}, 3'd1, 2'd0, 0, 0);
    dig({nm, "_p2"}, code[11:8],  2'd2, {8'h0, code[15:8]},   3'd2, 2'd0, 0, 0);
    dig({nm, "_p3"}, code[7:4],   2'd2, {4'h0, code[15:4]},   3'd3, 2'd0, 0, 0);
    dig({nm, "_p4"}, code[3:0],   2'd1, 16'h0,                3'd0, 2'd0, 0, 0);
  endtask

  // Enter 1,2,3,5 from LOCKED with fail_cnt=fc; final result given.
  task automatic wrong(input string nm, input logic [1:0] fc,
                       input logic [1:0] st_f, input logic [1:0] fc_f,
                       input logic [2:0] lol_f);
    dig({nm, "_w1"}, 4'h1, 2'd0, 16'h0001, 3'd1, fc, 0, 0);
    dig({nm, "_w2"}, 4'h2, 2'd0, 16'h0012, 3'd2, fc, 0, 0);
    dig({nm, "_w3"}, 4'h3, 2'd0, 16'h0123, 3'd3, fc, 0, 0);
    dig({nm, "_w4"}, 4'h5, st_f, 16'h0000, 3'd0, fc_f, 1, lol_f);
  endtask

  task automatic do_lock(input string nm);
    step(nm, 1, 0, 0, 0, 4'h0, 2'd0, 16'h0, 3'd0, 2'd0, 0, 0);
  endtask

  initial begin
    lock_req = 0; prog_req = 0; clear = 0; digit_valid = 0; digit_in = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #3;
    check("reset_state", state, 0);
    check("reset_entry", entry, 0);
    check("reset_cnt", entry_cnt, 0);
    check("reset_fail", fail_cnt, 0);
    check("reset_bad", bad_code, 0);
    check("reset_left", lockout_left, 0);
    #7 rst = 1'b1;
    @(posedge clk);
    #1;

    // Correct default code, then relock.
    unlock4("ok", 16'h1234, 2'd0);
    do_lock("ok_lock");

    // Three wrong codes -> lockout; digits during lockout are ignored.
    wrong("f1", 2'd0, 2'd0, 2'd1, 3'd0);
    wrong("f2", 2'd1, 2'd0, 2'd2, 3'd0);
    wrong("f3", 2'd2, 2'd3, 2'd3, 3'd7);
    for (int i = 6; i >= 0; i--)
      dig("lockout", 4'h1, 2'd3, 16'h0, 3'd0, 2'd3, 0, 3'(i));
    dig("lockout_exit", 4'h1, 2'd0, 16'h0, 3'd0, 2'd0, 0, 0);
    step("post_lockout", 1, 0, 0, 0, 4'h0, 2'd0, 16'h0, 3'd0, 2'd0, 0, 0);

    // Reprogram to ABCD; old code now fails, new one unlocks.
    unlock4("rp_u", 16'h1234, 2'd0);
    step("rp_prog", 0, 1, 0, 0, 4'h0, 2'd2, 16'h0, 3'd0, 2'd0, 0, 0);
    program4("rp", 16'hABCD);
    do_lock("rp_lock");
    wrong("rp_old", 2'd0, 2'd0, 2'd1, 3'd0);  // 1,2,3,5 also mismatches ABCD
    dig("rp_old1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd1, 0, 0);
    dig("rp_old2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd1, 0, 0);
    dig("rp_old3", 4'h3, 2'd0, 16'h0123, 3'd3, 2'd1, 0, 0);
    dig("rp_old4", 4'h4, 2'd0, 16'h0000, 3'd0, 2'd2, 1, 0);
    unlock4("rp_new", 16'hABCD, 2'd2);
    step("rp_back", 0, 1, 0, 0, 4'h0, 2'd2, 16'h0, 3'd0, 2'd0, 0, 0);
    program4("rp_restore", 16'h1234);
    do_lock("rp_lock2");

    // Abort programming: code stays 1234.
    unlock4("ab_u", 16'h1234, 2'd0);
    step("ab_prog", 0, 1, 0, 0, 4'h0, 2'd2, 16'h0, 3'd0, 2'd0, 0, 0);
    dig("ab_9a", 4'h9, 2'd2, 16'h0009, 3'd1, 2'd0, 0, 0);
    dig("ab_9b", 4'h9, 2'd2, 16'h0099, 3'd2, 2'd0, 0, 0);
    do_lock("ab_abort");
    unlock4("ab_chk", 16'h1234, 2'd0);
    do_lock("ab_lock");

    // Clear, and priority between same-cycle inputs.
    dig("cl_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd0, 0, 0);
    dig("cl_2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd0, 0, 0);
    step("cl_clear", 0, 0, 1, 0, 4'h0, 2'd0, 16'h0, 3'd0, 2'd0, 0, 0);
    unlock4("cl_u", 16'h1234, 2'd0);
    do_lock("cl_lock");
    dig("pri_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd0, 0, 0);
    step("pri_clr_dv", 0, 0, 1, 1, 4'h7, 2'd0, 16'h0, 3'd0, 2'd0, 0, 0);
    step("pri_prog_dv", 0, 1, 0, 1, 4'h3, 2'd0, 16'h0, 3'd0, 2'd0, 0, 0);
    step("pri_lock_dv", 1, 0, 0, 1, 4'h3, 2'd0, 16'h0, 3'd0, 2'd0, 0, 0);

    // Async reset mid-entry, after reprogramming to ABCD: code must revert.
    unlock4("ar_u", 16'h1234, 2'd0);
    step("ar_prog", 0, 1, 0, 0, 4'h0, 2'd2, 16'h0, 3'd0, 2'd0, 0, 0);
    program4("ar", 16'hABCD);
    do_lock("ar_lock");
    dig("ar_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd0, 0, 0);
    dig("ar_2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_entry", entry, 0);
    check("async_cnt", entry_cnt, 0);
    check("async_state", state, 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    unlock4("ar_default", 16'h1234, 2'd0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
